nanoz80_uart: RTL and testbench

- Z80 I/O-mapped UART peripheral, downstream of the address decoder.
- Enabled by the decoder's UART chip select, which covers ports 0x70-0x73; the block decodes addr_i[1:0] for the register offset.
- Provides an 8N1 transmitter with a one-entry holding register and a receiver with a small RX FIFO.
- Registered read data is muxed onto the CPU data bus by the top level.

---
 rtl/nanoz80_uart_pkg.sv | 25 ++
 rtl/nanoz80_uart_fifo.sv | 44 ++++
 rtl/nanoz80_uart.sv | 249 ++++++++++++++++++++++++
 tb/tb_nanoz80_uart.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nanoz80_uart_pkg.sv
// nanoz80_uart shared definitions: register offsets, bit indices, FSM states.
// Optional interrupt support is enabled with NANOZ80_UART_IRQ_EN.
package nanoz80_uart_pkg;

   localparam logic [1:0] OFF_DATA   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_CTRL   = 2'd2;
   localparam logic [1:0] OFF_IER    = 2'd3;

   localparam int ST_RX_AVAIL  = 0;
   localparam int ST_TX_READY  = 1;
   localparam int ST_OVERRUN   = 2;
   localparam int ST_FRAME_ERR = 3;

   localparam int CTRL_CLR  = 0;
   localparam int CTRL_LOOP = 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_st_e;

endpackage

// File: rtl/nanoz80_uart_fifo.sv
// Synchronous FIFO with full/empty flags; push and pop may share a cycle,
// including a push into a full FIFO that is popped in the same cycle.
module nanoz80_uart_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wp_q, rp_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty_o = (wp_q == rp_q);
   assign full_o  = (wp_q[AW] != rp_q[AW]) &&
                    (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign dout_o  = mem_q[rp_q[AW-1:0]];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         if (do_push) wp_q <= wp_q + 1'b1;
         if (do_pop)  rp_q <= rp_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wp_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/nanoz80_uart.sv
// Z80 I/O-mapped 8N1 UART: TX holding register, RX FIFO, status/ctrl regs.
// Define NANOZ80_UART_IRQ_EN to add the IER register and int_n_o output.
module nanoz80_uart
   import nanoz80_uart_pkg::*;
#(
   parameter int CLK_DIV  = 234,
   parameter int RX_DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       cs_i,
   input  logic       wr_n,
   input  logic       rd_n,
   input  logic [1:0] addr_i,
   input  logic [7:0] data_i,
   output logic [7:0] data_o,
   output logic       uart_tx_o,
   input  logic       uart_rx_i
`ifdef NANOZ80_UART_IRQ_EN
   ,
   output logic       int_n_o
`endif
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] DIV_M1  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);

   logic       wr_act, rd_act, wr_act_q, rd_act_q, wr_fire, rd_fire;
   logic       wr_data, wr_ctrl, clr;
   logic [7:0] data_q, rd_val;
   logic       loop_q, ovr_q, ferr_q;

   logic       hold_full_q, tx_q;
   logic [7:0] hold_q, tx_sh_q;
   logic [2:0] tx_bit_q;
   logic [CW-1:0] tx_cnt_q;
   uart_st_e   tx_st_q;

   logic [1:0] rx_sync_q;
   logic       rx_s, rx_done, rx_push, ferr_ev, ovr_ev;
   logic [7:0] rx_sh_q;
   logic [2:0] rx_bit_q;
   logic [CW-1:0] rx_cnt_q;
   uart_st_e   rx_st_q;

   logic       f_pop, f_full, f_empty;
   logic [7:0] f_dout;

   assign wr_act  = cs_i & ~wr_n;
   assign rd_act  = cs_i & ~rd_n;
   assign wr_fire = wr_act & ~wr_act_q;
   assign rd_fire = rd_act & ~rd_act_q;
   assign wr_data = wr_fire && (addr_i == OFF_DATA);
   assign wr_ctrl = wr_fire && (addr_i == OFF_CTRL);
   assign clr     = wr_ctrl & data_i[CTRL_CLR];
   assign f_pop   = rd_fire && (addr_i == OFF_DATA) && !f_empty;

   assign rx_s    = loop_q ? tx_q : rx_sync_q[1];
   assign rx_done = (rx_st_q == S_STOP) && (rx_cnt_q == DIV_M1);
   assign rx_push = rx_done & rx_s;
   assign ferr_ev = rx_done & ~rx_s;
   // A pop in the same cycle frees a slot, so only an unpopped full FIFO overruns
   assign ovr_ev  = rx_push & f_full & ~f_pop;

   assign data_o    = data_q;
   assign uart_tx_o = tx_q;

`ifdef NANOZ80_UART_IRQ_EN
   logic [1:0] ier_q;
   logic       int_n_q;

   assign int_n_o = int_n_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ier_q   <= '0;
         int_n_q <= 1'b1;
      end else begin
         if (wr_fire && (addr_i == OFF_IER)) ier_q <= data_i[1:0];
         int_n_q <= ~((ier_q[0] & ~f_empty) | (ier_q[1] & ~hold_full_q));
      end
   end
`endif

   always_comb begin
      rd_val = 8'h00;
      unique case (addr_i)
         OFF_DATA:   rd_val = f_empty ? 8'h00 : f_dout;
         OFF_STATUS: rd_val = {4'b0, ferr_q, ovr_q, ~hold_full_q, ~f_empty};
         OFF_CTRL:   rd_val = {6'b0, loop_q, 1'b0};
`ifdef NANOZ80_UART_IRQ_EN
         OFF_IER:    rd_val = {6'b0, ier_q};
`else
         OFF_IER:    rd_val = 8'h00;
`endif
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_act_q <= 1'b0;
         rd_act_q <= 1'b0;
         data_q   <= '0;
         loop_q   <= 1'b0;
         ovr_q    <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         wr_act_q <= wr_act;
         rd_act_q <= rd_act;
         if (rd_fire)     data_q <= rd_val;
         else if (!rd_act) data_q <= '0;
         if (wr_ctrl) loop_q <= data_i[CTRL_LOOP];
         ovr_q  <= (ovr_q & ~clr) | ovr_ev;
         ferr_q <= (ferr_q & ~clr) | ferr_ev;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tx_st_q     <= S_IDLE;
         tx_cnt_q    <= '0;
         tx_bit_q    <= '0;
         tx_sh_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         tx_q        <= 1'b1;
      end else begin
         if (wr_data && !hold_full_q) begin
            hold_q      <= data_i;
            hold_full_q <= 1'b1;
         end
         unique case (tx_st_q)
            S_IDLE: begin
               if (hold_full_q) begin
                  tx_sh_q     <= hold_q;
                  hold_full_q <= 1'b0;
                  tx_cnt_q    <= '0;
                  tx_q        <= 1'b0;
                  tx_st_q     <= S_START;
               end
            end
            S_START: begin
               if (tx_cnt_q == DIV_M1) begin
                  tx_cnt_q <= '0;
                  tx_bit_q <= '0;
                  tx_q     <= tx_sh_q[0];
                  tx_st_q  <= S_DATA;
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            S_DATA: begin
               if (tx_cnt_q == DIV_M1) begin
                  tx_cnt_q <= '0;
                  if (tx_bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     tx_st_q <= S_STOP;
                  end else begin
                     tx_bit_q <= tx_bit_q + 1'b1;
                     tx_sh_q  <= tx_sh_q >> 1;
                     tx_q     <= tx_sh_q[1];
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            S_STOP: begin
               if (tx_cnt_q == DIV_M1) begin
                  tx_cnt_q <= '0;
                  // Chain straight into the next start bit when a byte waits
                  if (hold_full_q) begin
                     tx_sh_q     <= hold_q;
                     hold_full_q <= 1'b0;
                     tx_q        <= 1'b0;
                     tx_st_q     <= S_START;
                  end else begin
                     tx_st_q <= S_IDLE;
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rx_sync_q <= 2'b11;
         rx_st_q   <= S_IDLE;
         rx_cnt_q  <= '0;
         rx_bit_q  <= '0;
         rx_sh_q   <= '0;
      end else begin
         rx_sync_q <= {rx_sync_q[0], uart_rx_i};
         unique case (rx_st_q)
            S_IDLE: begin
               if (!rx_s) begin
                  rx_cnt_q <= '0;
                  rx_st_q  <= S_START;
               end
            end
            S_START: begin
               if (rx_cnt_q == HALF_M1) begin
                  rx_cnt_q <= '0;
                  rx_bit_q <= '0;
                  rx_st_q  <= rx_s ? S_IDLE : S_DATA;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            S_DATA: begin
               if (rx_cnt_q == DIV_M1) begin
                  rx_cnt_q <= '0;
                  rx_sh_q  <= {rx_s, rx_sh_q[7:1]};
                  if (rx_bit_q == 3'd7) rx_st_q <= S_STOP;
                  else rx_bit_q <= rx_bit_q + 1'b1;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            S_STOP: begin
               if (rx_cnt_q == DIV_M1) begin
                  rx_cnt_q <= '0;
                  rx_st_q  <= S_IDLE;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
         endcase
      end
   end

   nanoz80_uart_fifo #(
      .DEPTH (RX_DEPTH),
      .WIDTH (8)
   ) u_rx_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (rx_push),
      .pop_i   (f_pop),
      .din_i   (rx_sh_q),
      .dout_o  (f_dout),
      .full_o  (f_full),
      .empty_o (f_empty)
   );

endmodule

// File: tb/tb_nanoz80_uart.sv
// Self-checking bench for nanoz80_uart with a queue-based serial/FIFO model.
// Define NANOZ80_UART_IRQ_EN to also exercise the interrupt output.
module tb_nanoz80_uart;

   localparam int DIV   = 16;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cs = 1'b0;
   logic       wr_n = 1'b1;
   logic       rd_n = 1'b1;
   logic [1:0] addr = 2'd0;
   logic [7:0] din = 8'h00;
   logic [7:0] dout;
   logic       tx;
   logic       rx = 1'b1;
`ifdef NANOZ80_UART_IRQ_EN
   logic       int_n;
`endif

   int vec = 0;
   int bad = 0;
   bit log_en = 1'b0;
   bit tx_log[$];

   nanoz80_uart #(.CLK_DIV(DIV), .RX_DEPTH(DEPTH)) dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .cs_i      (cs),
      .wr_n      (wr_n),
      .rd_n      (rd_n),
      .addr_i    (addr),
      .data_i    (din),
      .data_o    (dout),
      .uart_tx_o (tx),
`ifdef NANOZ80_UART_IRQ_EN
      .int_n_o   (int_n),
`endif
      .uart_rx_i (rx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (log_en) tx_log.push_back(tx);

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   // 8N1 line level for bit slot i of a frame carrying byte b
   function automatic bit frame_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return b[i-1];
      return 1'b1;
   endfunction

   function automatic int first_low();
      for (int i = 0; i < tx_log.size(); i++)
         if (tx_log[i] == 1'b0) return i;
      return -1;
   endfunction

   task automatic wr(input logic [1:0] a, input logic [7:0] d, input int hold);
      @(posedge clk); #1;
      cs = 1'b1; wr_n = 1'b0; addr = a; din = d;
      repeat (hold) @(posedge clk);
      #1;
      cs = 1'b0; wr_n = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] d);
      @(posedge clk); #1;
      cs = 1'b1; rd_n = 1'b0; addr = a;
      @(posedge clk); #1;
      d = dout;
      cs = 1'b0; rd_n = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop);
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         rx = (i == 9) ? stop : frame_bit(b, i);
         repeat (DIV) @(posedge clk);
         #1;
      end
      rx = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   task automatic test_reset();
      logic [7:0] v;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vec++;
      if (tx !== 1'b1) begin
         bad++; $display("FAIL reset_tx: got %b want 1", tx);
      end
      vec++;
      if (dout !== 8'h00) begin
         bad++; $display("FAIL reset_data_o: got %h want 00", dout);
      end
      @(negedge clk); rst_n = 1'b1;
      rd(2'd1, v);
      vec++;
      if (v !== 8'h02) begin
         bad++; $display("FAIL reset_status: got %h want 02", v);
      end
      rd(2'd2, v);
      vec++;
      if (v !== 8'h00) begin
         bad++; $display("FAIL reset_ctrl: got %h want 00", v);
      end
      rd(2'd0, v);
      vec++;
      if (v !== 8'h00) begin
         bad++; $display("FAIL reset_empty_read: got %h want 00", v);
      end
   endtask

   task automatic test_tx_frame();
      int st;
      int errs;
      tx_log.delete();
      log_en = 1'b1;
      wr(2'd0, 8'hA5, 3);
      repeat (12 * DIV) @(posedge clk);
      log_en = 1'b0;
      st = first_low();
      vec++;
      if (st < 0) begin
         bad++; $display("FAIL tx_start: got no start bit want start bit");
      end else begin
         for (int b = 0; b < 10; b++) begin
            errs = 0;
            for (int s = 0; s < DIV; s++)
               if (tx_log[st + b*DIV + s] != frame_bit(8'hA5, b)) errs++;
            vec++;
            if (errs != 0) begin
               bad++;
               $display("FAIL tx_a5_bit%0d: got %0d wrong samples want level %b",
                        b, errs, frame_bit(8'hA5, b));
            end
         end
         errs = 0;
         for (int i = st + 10*DIV; i < tx_log.size(); i++)
            if (tx_log[i] != 1'b1) errs++;
         vec++;
         if (errs != 0) begin
            bad++; $display("FAIL tx_single_frame: got %0d low samples after stop want 0", errs);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b1, b2, b3, v;
      int st;
      int errs;
      b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
      tx_log.delete();
      log_en = 1'b1;
      wr(2'd0, b1, 1);
      wr(2'd0, b2, 1);
      rd(2'd1, v);
      vec++;
      if (v !== 8'h00) begin
         bad++; $display("FAIL b2b_not_ready: got %h want 00", v);
      end
      wr(2'd0, b3, 1);
      repeat (22 * DIV) @(posedge clk);
      log_en = 1'b0;
      st = first_low();
      vec++;
      if (st < 0) begin
         bad++; $display("FAIL b2b_start: got no start bit want start bit");
      end else begin
         for (int b = 0; b < 20; b++) begin
            errs = 0;
            for (int s = 0; s < DIV; s++)
               if (tx_log[st + b*DIV + s] != frame_bit((b < 10) ? b1 : b2, b % 10)) errs++;
            vec++;
            if (errs != 0) begin
               bad++;
               $display("FAIL b2b_bit%0d: got %0d wrong samples want level %b",
                        b, errs, frame_bit((b < 10) ? b1 : b2, b % 10));
            end
         end
         errs = 0;
         for (int i = st + 20*DIV; i < tx_log.size(); i++)
            if (tx_log[i] != 1'b1) errs++;
         vec++;
         if (errs != 0) begin
            bad++; $display("FAIL b2b_dropped: got %0d low samples want 0", errs);
         end
      end
      rd(2'd1, v);
      vec++;
      if (v !== 8'h02) begin
         bad++; $display("FAIL b2b_ready_after: got %h want 02", v);
      end
   endtask

   task automatic test_loopback();
      logic [7:0] b, v;
      wr(2'd2, 8'h02, 1);
      rd(2'd2, v);
      vec++;
      if (v !== 8'h02) begin
         bad++; $display("FAIL loop_ctrl: got %h want 02", v);
      end
      for (int k = 0; k < 4; k++) begin
         b = (k == 0) ? 8'h3C : 8'($urandom);
         wr(2'd0, b, 1);
         repeat (11 * DIV) @(posedge clk);
         rd(2'd1, v);
         vec++;
         if (v !== 8'h03) begin
            bad++; $display("FAIL loop_avail%0d: got %h want 03", k, v);
         end
         rd(2'd0, v);
         vec++;
         if (v !== b) begin
            bad++; $display("FAIL loop_data%0d: got %h want %h", k, v, b);
         end
         rd(2'd1, v);
         vec++;
         if (v !== 8'h02) begin
            bad++; $display("FAIL loop_empty%0d: got %h want 02", k, v);
         end
      end
      wr(2'd2, 8'h00, 1);
   endtask

   task automatic test_overrun();
      logic [7:0] q[$];
      logic [7:0] b, v, first;
      bit ovr;
      ovr = 1'b0;
      for (int k = 0; k < DEPTH + 1; k++) begin
         b = 8'($urandom);
         send_frame(b, 1'b1);
         if (q.size() < DEPTH) q.push_back(b);
         else ovr = 1'b1;
      end
      rd(2'd1, v);
      vec++;
      if (v !== {5'b0, ovr, 2'b11}) begin
         bad++; $display("FAIL ovr_status: got %h want %h", v, {5'b0, ovr, 2'b11});
      end
      first = q.pop_front();
      @(posedge clk); #1;
      cs = 1'b1; rd_n = 1'b0; addr = 2'd0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         vec++;
         if (dout !== first) begin
            bad++; $display("FAIL ovr_hold%0d: got %h want %h", c, dout, first);
         end
      end
      cs = 1'b0; rd_n = 1'b1;
      @(posedge clk); #1;
      vec++;
      if (dout !== 8'h00) begin
         bad++; $display("FAIL ovr_release: got %h want 00", dout);
      end
      while (q.size() > 0) begin
         b = q.pop_front();
         rd(2'd0, v);
         vec++;
         if (v !== b) begin
            bad++; $display("FAIL ovr_pop: got %h want %h", v, b);
         end
      end
      rd(2'd0, v);
      vec++;
      if (v !== 8'h00) begin
         bad++; $display("FAIL ovr_empty_read: got %h want 00", v);
      end
      rd(2'd1, v);
      vec++;
      if (v !== 8'h06) begin
         bad++; $display("FAIL ovr_sticky: got %h want 06", v);
      end
      wr(2'd2, 8'h01, 1);
      rd(2'd1, v);
      vec++;
      if (v !== 8'h02) begin
         bad++; $display("FAIL ovr_clear: got %h want 02", v);
      end
      rd(2'd2, v);
      vec++;
      if (v !== 8'h00) begin
         bad++; $display("FAIL ctrl_selfclear: got %h want 00", v);
      end
   endtask

   task automatic test_frame_err_glitch();
      logic [7:0] b, v;
      b = 8'($urandom);
      send_frame(b, 1'b1);
      send_frame(8'($urandom), 1'b0);
      repeat (2 * DIV) @(posedge clk);
      rd(2'd1, v);
      vec++;
      if (v !== 8'h0B) begin
         bad++; $display("FAIL ferr_status: got %h want 0b", v);
      end
      rd(2'd0, v);
      vec++;
      if (v !== b) begin
         bad++; $display("FAIL ferr_fifo: got %h want %h", v, b);
      end
      rd(2'd0, v);
      vec++;
      if (v !== 8'h00) begin
         bad++; $display("FAIL ferr_discard: got %h want 00", v);
      end
      wr(2'd2, 8'h01, 1);
      @(posedge clk); #1;
      rx = 1'b0;
      repeat (DIV * 3 / 10) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (3 * DIV) @(posedge clk);
      rd(2'd1, v);
      vec++;
      if (v !== 8'h02) begin
         bad++; $display("FAIL glitch_status: got %h want 02", v);
      end
      b = 8'($urandom);
      send_frame(b, 1'b1);
      rd(2'd0, v);
      vec++;
      if (v !== b) begin
         bad++; $display("FAIL post_glitch_rx: got %h want %h", v, b);
      end
   endtask

   task automatic test_off3();
      logic [7:0] v;
      wr(2'd3, 8'hFF, 1);
      rd(2'd3, v);
      vec++;
`ifdef NANOZ80_UART_IRQ_EN
      if (v !== 8'h03) begin
         bad++; $display("FAIL off3_ier: got %h want 03", v);
      end
`else
      if (v !== 8'h00) begin
         bad++; $display("FAIL off3_ignored: got %h want 00", v);
      end
`endif
      wr(2'd3, 8'h00, 1);
   endtask

`ifdef NANOZ80_UART_IRQ_EN
   task automatic test_irq();
      logic [7:0] b;
      wr(2'd3, 8'h01, 1);
      repeat (2) @(posedge clk);
      #1;
      vec++;
      if (int_n !== 1'b1) begin
         bad++; $display("FAIL irq_idle: got %b want 1", int_n);
      end
      b = 8'($urandom);
      send_frame(b, 1'b1);
      vec++;
      if (int_n !== 1'b0) begin
         bad++; $display("FAIL irq_rx: got %b want 0", int_n);
      end
      @(posedge clk); #1;
      cs = 1'b1; rd_n = 1'b0; addr = 2'd0;
      @(posedge clk); #1;
      vec++;
      if (dout !== b || int_n !== 1'b0) begin
         bad++; $display("FAIL irq_pop_cycle: got %h/%b want %h/0", dout, int_n, b);
      end
      @(posedge clk); #1;
      vec++;
      if (int_n !== 1'b1) begin
         bad++; $display("FAIL irq_release: got %b want 1", int_n);
      end
      cs = 1'b0; rd_n = 1'b1;
      wr(2'd3, 8'h02, 1);
      repeat (2) @(posedge clk);
      #1;
      vec++;
      if (int_n !== 1'b0) begin
         bad++; $display("FAIL irq_tx_ready: got %b want 0", int_n);
      end
      wr(2'd3, 8'h00, 1);
      repeat (2) @(posedge clk);
      #1;
      vec++;
      if (int_n !== 1'b1) begin
         bad++; $display("FAIL irq_disable: got %b want 1", int_n);
      end
   endtask
`endif

   task automatic test_async_reset();
      logic [7:0] v;
      int errs;
      wr(2'd0, 8'($urandom), 1);
      repeat (3) @(posedge clk);
      #1;
      vec++;
      if (tx !== 1'b0) begin
         bad++; $display("FAIL arst_in_start: got %b want 0", tx);
      end
      #2;
      rst_n = 1'b0;
      #1;
      vec++;
      if (tx !== 1'b1) begin
         bad++; $display("FAIL arst_tx_high: got %b want 1", tx);
      end
      @(negedge clk); rst_n = 1'b1;
      errs = 0;
      for (int i = 0; i < 12 * DIV; i++) begin
         @(posedge clk); #1;
         if (tx !== 1'b1) errs++;
      end
      vec++;
      if (errs != 0) begin
         bad++; $display("FAIL arst_abort: got %0d low samples want 0", errs);
      end
      rd(2'd1, v);
      vec++;
      if (v !== 8'h02) begin
         bad++; $display("FAIL arst_status: got %h want 02", v);
      end
   endtask

   initial begin
      test_reset();
      test_tx_frame();
      test_back_to_back();
      test_loopback();
      test_overrun();
      test_frame_err_glitch();
      test_off3();
`ifdef NANOZ80_UART_IRQ_EN
      test_irq();
`endif
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
